aes_ctr_ctrl: RTL and testbench

AES_CTR_CTRL -- requirements
Module: aes_ctr_ctrl

---
 rtl/aes_ctr_pkg.sv | 23 ++
 rtl/aes_ctr_ctrl_if.sv | 35 +++
 rtl/aes_ctr_fifo.sv | 52 +++++
 rtl/aes_ctr_ctrl.sv | 112 +++++++++++
 tb/tb_aes_ctr_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_ctr_pkg.sv
// Shared widths, default parameters and types for the AES-CTR stream controller.
// The 129-bit beat pairs one 128-bit block with its end-of-message flag.
package aes_ctr_pkg;

  localparam int BLOCK_W            = 128;
  localparam int NONCE_W            = 96;
  localparam int CTR_W              = 32;
  localparam int LATENCY_DEFAULT    = 20;
  localparam int FIFO_DEPTH_DEFAULT = 32;
  localparam int BEAT_W             = BLOCK_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [BLOCK_W-1:0] data;
    logic               last;
  } beat_t;

endpackage

// File: rtl/aes_ctr_ctrl_if.sv
// Bundles the configuration, plaintext, keystream and ciphertext signals of aes_ctr_ctrl.
// The slave modport is the controller's view; master is the driving side.
interface aes_ctr_ctrl_if;
  import aes_ctr_pkg::*;

  logic               cfg_load;
  logic [NONCE_W-1:0] cfg_nonce;
  logic [CTR_W-1:0]   cfg_ctr_init;
  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_data;
  logic               in_last;
  logic [BLOCK_W-1:0] aes_state;
  logic [BLOCK_W-1:0] aes_out;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_data;
  logic               out_last;
  logic               busy;

  modport slave (
    input  cfg_load, cfg_nonce, cfg_ctr_init,
    input  in_valid, in_data, in_last,
    input  aes_out, out_ready,
    output in_ready, aes_state, out_valid, out_data, out_last, busy
  );

  modport master (
    output cfg_load, cfg_nonce, cfg_ctr_init,
    output in_valid, in_data, in_last,
    output aes_out, out_ready,
    input  in_ready, aes_state, out_valid, out_data, out_last, busy
  );

endinterface

// File: rtl/aes_ctr_fifo.sv
// Synchronous FIFO with occupancy count; memory is unreset, only pointers and count clear.
// Callers must never push when full or pop when empty.
module aes_ctr_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/aes_ctr_ctrl.sv
// AES-CTR stream controller: issues counter blocks to an external aes_128 pipeline,
// delays plaintext to meet its keystream, XORs them and buffers ciphertext in a FIFO.
module aes_ctr_ctrl
  import aes_ctr_pkg::*;
#(
  parameter int LATENCY    = LATENCY_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  aes_ctr_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_e             state_q, state_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [LATENCY-1:0] vld_q;
  beat_t              dly_q [LATENCY];

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  beat_t              push_beat, fifo_dout;
  logic               ready, accept, tap_valid, pop, credit_ok;

  // A beat is only admitted if its eventual FIFO slot is already reserved.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign ready     = (state_q == RUN) && credit_ok;
  assign accept    = bus.in_valid & ready;
  assign tap_valid = vld_q[LATENCY-1];
  assign pop       = !fifo_empty & bus.out_ready;

  always_comb begin
    state_d = state_q;
    nonce_d = nonce_q;
    ctr_d   = ctr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cfg_load) begin
          state_d = RUN;
          nonce_d = bus.cfg_nonce;
          ctr_d   = bus.cfg_ctr_init;
        end
      end
      RUN: begin
        if (accept) ctr_d = ctr_q + CTR_W'(1);
        if (accept && bus.in_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (inflight_q == '0 && fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !tap_valid)      inflight_d = inflight_q + CNT_W'(1);
    else if (!accept && tap_valid) inflight_d = inflight_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      nonce_q    <= '0;
      ctr_q      <= '0;
      inflight_q <= '0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      nonce_q    <= nonce_d;
      ctr_q      <= ctr_d;
      inflight_q <= inflight_d;
      vld_q[0]   <= accept;
      for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Payload stages carry no reset; only the valid bits decide what reaches the FIFO.
  always_ff @(posedge clk) begin
    dly_q[0] <= '{data: bus.in_data, last: bus.in_last};
    for (int i = 1; i < LATENCY; i++) dly_q[i] <= dly_q[i-1];
  end

  assign push_beat = '{data: bus.aes_out ^ dly_q[LATENCY-1].data,
                       last: dly_q[LATENCY-1].last};

  aes_ctr_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tap_valid),
    .din_i   (push_beat),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign bus.in_ready  = ready;
  assign bus.aes_state = {nonce_q, ctr_q};
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : fifo_dout.data;
  assign bus.out_last  = !fifo_empty & fifo_dout.last;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// Randomised scoreboard bench for aes_ctr_ctrl with a behavioural keystream pipeline
// standing in for aes_128; expected ciphertext comes from nonce/counter arithmetic.
module tb_aes_ctr_ctrl;

  localparam int LATENCY    = 20;
  localparam int FIFO_DEPTH = 32;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  aes_ctr_ctrl_if bus ();

  aes_ctr_ctrl #(
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int           vectors     = 0;
  int           miscompares = 0;
  exp_t         expQ[$];
  logic [95:0]  modelNonce  = '0;
  logic [31:0]  modelCtr    = '0;
  logic [127:0] lastAesState;
  int           lastWait;
  int           readyMode   = 0;
  bit           lastPopSeen = 0;
  bit           holdArmed   = 0;
  logic [127:0] holdData;
  logic         holdLast;

  // Stand-in keystream: any fixed, state-sensitive mixing of the counter block.
  function automatic logic [127:0] keystream(input logic [127:0] s);
    return (s * 128'h9e3779b97f4a7c15f39cc0605cedc835) ^ {s[63:0], s[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_6969_9696;
  endfunction

  // Behavioural aes_128: a LATENCY-deep pipeline from aes_state to aes_out.
  logic [127:0] aesPipe [LATENCY];
  always @(posedge clk) begin
    aesPipe[0] <= bus.aes_state;
    for (int i = 1; i < LATENCY; i++) aesPipe[i] <= aesPipe[i-1];
  end
  assign bus.aes_out = keystream(aesPipe[LATENCY-1]);

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s", name);
  endtask

  // out_ready driver: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: pops the scoreboard on every handshake and checks hold stability.
  always @(negedge clk) begin
    if (rst) begin
      holdArmed = 0;
    end else begin
      if (holdArmed) begin
        checkOutput("hold_valid", bus.out_valid, 1'b1);
        checkOutput("hold_data", {bus.out_data, bus.out_last}, {holdData, holdLast});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) begin
          failNow("unexpected_output");
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("out_data", bus.out_data, e.data);
          checkOutput("out_last", bus.out_last, e.last);
          if (e.last) lastPopSeen = 1;
        end
      end
      holdArmed = bus.out_valid && !bus.out_ready;
      holdData  = bus.out_data;
      holdLast  = bus.out_last;
    end
  end

  // Called at posedge+1; offers one block until accepted or the budget expires.
  task automatic applyStimulus(input logic [127:0] d, input logic l, input bit mayStall,
                               input int budget, output bit taken);
    int n;
    exp_t e;
    n = 0;
    taken = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!taken && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.in_ready) begin
        taken = 1;
        lastAesState = bus.aes_state;
        lastWait = n;
        checkOutput("aes_state", bus.aes_state, {modelNonce, modelCtr});
        e.data = d ^ keystream({modelNonce, modelCtr});
        e.last = l;
        expQ.push_back(e);
        modelCtr = modelCtr + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (!taken && !mayStall) failNow("accept_timeout");
  endtask

  task automatic applyConfig(input logic [95:0] nonce, input logic [31:0] ctr, input bit expectTaken);
    bus.cfg_load     = 1'b1;
    bus.cfg_nonce    = nonce;
    bus.cfg_ctr_init = ctr;
    @(posedge clk);
    #1;
    bus.cfg_load = 1'b0;
    if (expectTaken) begin
      modelNonce = nonce;
      modelCtr   = ctr;
    end
    checkOutput("busy_after_cfg", bus.busy, 1'b1);
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || expQ.size() != 0) && n < budget);
    if (bus.busy || expQ.size() != 0) failNow("idle_timeout");
    checkOutput("idle_out_valid", bus.out_valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit taken;
    int n;
    int accepted;
    bit bad;
    logic [127:0] f51 [4];
    logic [31:0]  wrapExp [4];
    logic [95:0]  nonceT2;
    f51[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    f51[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    f51[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    f51[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    wrapExp[0] = 32'hffffffff;
    wrapExp[1] = 32'h00000000;
    wrapExp[2] = 32'h00000001;
    wrapExp[3] = 32'h00000002;

    bus.cfg_load = 0; bus.cfg_nonce = '0; bus.cfg_ctr_init = '0;
    bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0;

    // Reset values, both during and after reset.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", bus.in_ready, 1'b0);
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_aes_state", bus.aes_state, 128'h0);
    checkOutput("rst_out_data", bus.out_data, 128'h0);
    checkOutput("rst_out_last", bus.out_last, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", bus.in_ready, 1'b0);
    checkOutput("post_rst_busy", bus.busy, 1'b0);
    checkOutput("post_rst_aes_state", bus.aes_state, 128'h0);

    // F.5.1 stimulus, first-block latency, then the rest of the message.
    $display("[TB] test: F.5.1 stimulus and latency");
    readyMode = 0;
    applyConfig(96'hf0f1f2f3f4f5f6f7f8f9fafb, 32'hfcfdfeff, 1);
    applyStimulus(f51[0], 1'b0, 0, 10, taken);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 100);
    checkOutput("first_latency", 160'(n), 160'(LATENCY + 1));
    @(posedge clk);
    #1;
    for (int i = 1; i < 4; i++) applyStimulus(f51[i], 1'(i == 3), 0, 10, taken);
    waitIdle(200);

    // Counter wrap with back-to-back blocks.
    $display("[TB] test: counter wrap");
    nonceT2 = rand128()[95:0];
    applyConfig(nonceT2, 32'hffffffff, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(rand128(), 1'(i == 3), 0, 10, taken);
      checkOutput("wrap_ctr", lastAesState[31:0], wrapExp[i]);
      checkOutput("wrap_nonce", lastAesState[127:32], nonceT2);
      checkOutput("b2b_wait", 160'(lastWait), 160'd1);
    end
    waitIdle(200);

    // Backpressure: exactly FIFO_DEPTH accepts while out_ready is held low.
    $display("[TB] test: backpressure");
    readyMode = 2;
    applyConfig(rand128()[95:0], $urandom(), 1);
    accepted = 0;
    for (int i = 0; i < FIFO_DEPTH + 8; i++) begin
      applyStimulus(rand128(), 1'b0, 1, 60, taken);
      if (!taken) break;
      accepted++;
    end
    checkOutput("bp_accepted", 160'(accepted), 160'(FIFO_DEPTH));
    checkOutput("bp_in_ready", bus.in_ready, 1'b0);
    readyMode = 0;
    applyStimulus(rand128(), 1'b1, 0, 200, taken);
    waitIdle(300);

    // Random in_valid gaps and out_ready, 200 blocks.
    $display("[TB] test: random stream");
    readyMode = 1;
    lastPopSeen = 0;
    applyConfig(rand128()[95:0], $urandom(), 1);
    for (int i = 1; i <= 200; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(rand128(), 1'(i == 200), 0, 200, taken);
    end
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!lastPopSeen && n < 3000);
    if (!lastPopSeen) failNow("last_pop_timeout");
    @(negedge clk);
    checkOutput("busy_at_final_pop", bus.busy, 1'b1);
    @(negedge clk);
    checkOutput("busy_after_final_pop", bus.busy, 1'b0);
    checkOutput("idle_in_ready", bus.in_ready, 1'b0);
    checkOutput("scoreboard_empty", 160'(expQ.size()), 160'd0);
    @(posedge clk);
    #1;
    readyMode = 0;

    // Reset in the middle of a stream.
    $display("[TB] test: reset mid-stream");
    applyConfig(rand128()[95:0], $urandom(), 1);
    for (int i = 0; i < 10; i++) applyStimulus(rand128(), 1'b0, 0, 10, taken);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", bus.out_valid, 1'b0);
    checkOutput("midrst_in_ready", bus.in_ready, 1'b0);
    checkOutput("midrst_busy", bus.busy, 1'b0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = rand128();
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid || bus.in_ready) bad = 1;
    end
    checkOutput("no_output_after_rst", bad, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    applyConfig(rand128()[95:0], $urandom(), 1);
    for (int i = 0; i < 3; i++) applyStimulus(rand128(), 1'(i == 2), 0, 10, taken);
    waitIdle(200);

    // cfg_load during RUN is ignored.
    $display("[TB] test: cfg_load during RUN");
    applyConfig(96'h0123456789abcdef01234567, 32'h00001000, 1);
    for (int i = 0; i < 3; i++) applyStimulus(rand128(), 1'b0, 0, 10, taken);
    applyConfig(96'hfedcba9876543210fedcba98, 32'h77770000, 0);
    for (int i = 0; i < 3; i++) applyStimulus(rand128(), 1'(i == 2), 0, 10, taken);
    checkOutput("ignored_cfg_ctr", lastAesState, {96'h0123456789abcdef01234567, 32'h00001005});
    waitIdle(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
